bus_handshake_transmitter: RTL and testbench

BUS_HANDSHAKE_TRANSMITTER -- requirements
Module: bus_handshake_transmitter

---
 rtl/bus_handshake_transmitter.sv | 110 +++++++++++
 tb/tb_bus_handshake_transmitter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_handshake_transmitter.sv
// Source-domain side of a four-phase request/acknowledge bus crossing.
// A word accepted from the local producer is parked on bus_data and held
// stable while request is raised; the destination's acknowledge is brought
// in through a flop synchronizer and walks the FSM back to IDLE.
// STAGE_COUNT must be at least 2 for the synchronizer to be meaningful.
module bus_handshake_transmitter #(
  parameter int BUS_WIDTH   = 8,
  parameter int STAGE_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  input  logic                 ack_async,
  output logic                 request,
  output logic [BUS_WIDTH-1:0] bus_data,
  output logic                 protocol_error
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK_HIGH,
    WAIT_ACK_LOW
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [STAGE_COUNT-1:0] ack_chain;
  logic                   ack_sync;
  logic                   accept;

  assign ack_sync = ack_chain[STAGE_COUNT-1];
  assign accept   = data_valid && data_ready;

  // Shift the asynchronous acknowledge through the synchronizer chain
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_chain <= '0;
    end else begin
      ack_chain <= {ack_chain[STAGE_COUNT-2:0], ack_async};
    end
  end

  // Handshake state register; reset aborts any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept a word, then wait for ack to rise and fall
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = WAIT_ACK_HIGH;
        end
      end
      WAIT_ACK_HIGH: begin
        if (ack_sync) begin
          state_next = WAIT_ACK_LOW;
        end
      end
      WAIT_ACK_LOW: begin
        if (!ack_sync) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Ready only when idle and the destination has fully released its ack
  always_comb begin
    data_ready = 1'b0;
    if (!reset && (state == IDLE) && !ack_sync) begin
      data_ready = 1'b1;
    end
  end

  // Launch register: capture the word and raise request on accept,
  // drop request once the acknowledge has been seen
  always_ff @(posedge clk) begin
    if (reset) begin
      request  <= 1'b0;
      bus_data <= '0;
    end else if (accept) begin
      request  <= 1'b1;
      bus_data <= data_in;
    end else if ((state == WAIT_ACK_HIGH) && ack_sync) begin
      request  <= 1'b0;
    end
  end

  // Sticky flag for an acknowledge that arrives with no request outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_error <= 1'b0;
    end else if ((state == IDLE) && ack_sync) begin
      protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_handshake_transmitter.sv
// Directed bench for bus_handshake_transmitter: a default 8-bit/2-stage
// instance walks through single transfers, held-valid transfers, a stalled
// handshake, a spurious acknowledge and a mid-handshake reset; a 16-bit
// 3-stage instance checks the synchronizer latency.
module tb_bus_handshake_transmitter;

  logic        clk;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        ack_async;
  logic        request;
  logic [7:0]  bus_data;
  logic        protocol_error;

  logic        b_reset;
  logic [15:0] b_data_in;
  logic        b_data_valid;
  logic        b_data_ready;
  logic        b_ack_async;
  logic        b_request;
  logic [15:0] b_bus_data;
  logic        b_protocol_error;

  int          check_count;
  int          error_count;
  int          accept_count;
  logic        req_prev;

  bus_handshake_transmitter #(
    .BUS_WIDTH  (8),
    .STAGE_COUNT(2)
  ) dut_a (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .ack_async     (ack_async),
    .request       (request),
    .bus_data      (bus_data),
    .protocol_error(protocol_error)
  );

  bus_handshake_transmitter #(
    .BUS_WIDTH  (16),
    .STAGE_COUNT(3)
  ) dut_b (
    .clk           (clk),
    .reset         (b_reset),
    .data_in       (b_data_in),
    .data_valid    (b_data_valid),
    .data_ready    (b_data_ready),
    .ack_async     (b_ack_async),
    .request       (b_request),
    .bus_data      (b_bus_data),
    .protocol_error(b_protocol_error)
  );

  // Free-running source clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, settle, and count rising edges of request
  task automatic tick();
    @(posedge clk);
    #1;
    if (request && !req_prev) begin
      accept_count++;
    end
    req_prev = request;
  endtask

  // Drive the producer and acknowledge inputs of the 8-bit instance
  task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ack);
    data_valid = valid;
    data_in    = data;
    ack_async  = ack;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected)
    else begin
      error_count++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence
  initial begin
    check_count  = 0;
    error_count  = 0;
    accept_count = 0;
    req_prev     = 1'b0;
    reset        = 1'b1;
    data_in      = 8'h00;
    data_valid   = 1'b0;
    ack_async    = 1'b0;
    b_reset      = 1'b1;
    b_data_in    = 16'h0000;
    b_data_valid = 1'b0;
    b_ack_async  = 1'b0;

    // Reset state
    tick();
    checkOutput("rst_request", request, 0);
    checkOutput("rst_bus_data", bus_data, 0);
    checkOutput("rst_error", protocol_error, 0);
    checkOutput("rst_ready_in_reset", data_ready, 0);
    reset = 1'b0;
    #1;
    checkOutput("rst_ready_first_cycle", data_ready, 1);

    // Single transfer of A5: accept at edge 1, ack stable before edge 4
    $display("[TB] single transfer");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("single_bus_data", bus_data, 32'hA5);
    checkOutput("single_request", request, 1);
    checkOutput("single_ready_busy", data_ready, 0);
    tick();
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("single_request_held_e5", request, 1);
    tick();
    checkOutput("single_request_drop_e6", request, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("single_ready_low_e8", data_ready, 0);
    tick();
    checkOutput("single_ready_high_e9", data_ready, 1);
    checkOutput("single_bus_data_held", bus_data, 32'hA5);

    // Valid held high, data changes 11 -> 22 mid-transfer
    $display("[TB] held valid");
    accept_count = 0;
    applyStimulus(1'b1, 8'h11, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h22, 1'b0);
    checkOutput("held_bus_data_11", bus_data, 32'h11);
    checkOutput("held_request", request, 1);
    tick();
    tick();
    checkOutput("held_bus_data_stable", bus_data, 32'h11);
    checkOutput("held_ready_busy", data_ready, 0);
    applyStimulus(1'b1, 8'h22, 1'b1);
    tick();
    tick();
    checkOutput("held_request_before_act", request, 1);
    tick();
    checkOutput("held_request_drop", request, 0);
    checkOutput("held_bus_data_after_ack", bus_data, 32'h11);
    applyStimulus(1'b1, 8'h22, 1'b0);
    tick();
    tick();
    checkOutput("held_bus_data_wait_low", bus_data, 32'h11);
    checkOutput("held_ready_wait_low", data_ready, 0);
    tick();
    checkOutput("held_ready_idle", data_ready, 1);
    checkOutput("held_bus_data_idle", bus_data, 32'h11);
    tick();
    checkOutput("held_bus_data_22", bus_data, 32'h22);
    checkOutput("held_request_22", request, 1);

    // Stalled handshake: ack stuck low for 50 cycles with valid high
    $display("[TB] stalled handshake");
    applyStimulus(1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput("stall_request", request, 1);
      checkOutput("stall_ready", data_ready, 0);
      checkOutput("stall_bus_data", bus_data, 32'h22);
    end
    checkOutput("held_accept_count", accept_count, 2);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("stall_release_request", request, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("stall_release_ready", data_ready, 1);

    // Spurious acknowledge while idle for three edges
    $display("[TB] spurious ack");
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    checkOutput("spur_ready_low", data_ready, 0);
    checkOutput("spur_error_not_yet", protocol_error, 0);
    applyStimulus(1'b1, 8'h55, 1'b1);
    tick();
    checkOutput("spur_error_set", protocol_error, 1);
    checkOutput("spur_no_accept", request, 0);
    applyStimulus(1'b1, 8'h55, 1'b0);
    tick();
    checkOutput("spur_ready_still_low", data_ready, 0);
    checkOutput("spur_no_accept_2", request, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("spur_ready_back", data_ready, 1);
    checkOutput("spur_error_sticky", protocol_error, 1);
    checkOutput("spur_bus_data_kept", bus_data, 32'h22);

    // Reset in WAIT_ACK_LOW discards the word and clears the error
    $display("[TB] mid-handshake reset");
    applyStimulus(1'b1, 8'h77, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("abort_request_low", request, 0);
    checkOutput("abort_bus_data_77", bus_data, 32'h77);
    reset = 1'b1;
    #1;
    checkOutput("abort_ready_in_reset", data_ready, 0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("abort_request", request, 0);
    checkOutput("abort_bus_data", bus_data, 0);
    checkOutput("abort_error_cleared", protocol_error, 0);
    checkOutput("abort_ready", data_ready, 1);
    applyStimulus(1'b1, 8'h3C, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("after_abort_bus_data", bus_data, 32'h3C);
    checkOutput("after_abort_request", request, 1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("after_abort_request_drop", request, 0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("after_abort_ready", data_ready, 1);
    checkOutput("after_abort_error", protocol_error, 0);

    // 16-bit, 3-stage instance: each ack edge acts 3 edges later
    $display("[TB] three-stage synchronizer");
    b_reset = 1'b0;
    #1;
    checkOutput("b_ready_after_reset", b_data_ready, 1);
    b_data_valid = 1'b1;
    b_data_in    = 16'hBEEF;
    tick();
    b_data_valid = 1'b0;
    b_data_in    = 16'h0000;
    checkOutput("b_bus_data", b_bus_data, 32'hBEEF);
    checkOutput("b_request", b_request, 1);
    b_ack_async = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("b_request_held_2", b_request, 1);
    tick();
    checkOutput("b_request_drop_3", b_request, 0);
    b_ack_async = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("b_ready_low_2", b_data_ready, 0);
    tick();
    checkOutput("b_ready_high_3", b_data_ready, 1);
    checkOutput("b_bus_data_held", b_bus_data, 32'hBEEF);
    checkOutput("b_error", b_protocol_error, 0);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
